// File: rtl/spec_ghr.sv
// Speculative global history register with a circular checkpoint buffer.
// Each predicted branch gets a checkpoint so that a mispredict or a flush can rebuild the history.
module spec_ghr #(
    parameter int HISTORY_SIZE = 64,
    parameter int CKPT_DEPTH   = 8,
    localparam int IDW         = $clog2(CKPT_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pred_valid,
    input  logic                    pred_taken,
    output logic                    pred_ready,
    output logic [IDW-1:0]          pred_id,
    input  logic                    res_valid,
    input  logic [IDW-1:0]          res_id,
    input  logic                    res_mispredict,
    input  logic                    res_taken,
    input  logic                    commit_valid,
    input  logic                    flush,
    output logic [HISTORY_SIZE-1:0] spec_history,
    output logic [HISTORY_SIZE-1:0] retired_history,
    output logic [IDW:0]            ckpt_count
);

    localparam logic [IDW-1:0] PTR_ONE = IDW'(1);
    localparam logic [IDW:0]   CNT_ONE = (IDW + 1)'(1);

    logic [HISTORY_SIZE-1:0] hist_mem [CKPT_DEPTH];
    logic [CKPT_DEPTH-1:0]   out_mem;

    logic [HISTORY_SIZE-1:0] spec_q, spec_d;
    logic [HISTORY_SIZE-1:0] ret_q, ret_d;
    logic [IDW-1:0]          head_q, head_d;
    logic [IDW-1:0]          tail_q, tail_d;
    logic [IDW:0]            count_q, count_d;

    logic [IDW-1:0] res_off;
    logic           in_flight;
    logic           mis_hit;
    logic           mis_acc;
    logic           push;
    logic           commit_acc;
    logic           commit_out;
    logic [IDW:0]   count_base;

    // The buffer is full exactly when the count reaches CKPT_DEPTH, a power of two.
    assign pred_ready = ~count_q[IDW];

    assign res_off    = res_id - head_q;
    assign in_flight  = {1'b0, res_off} < count_q;
    assign mis_hit    = res_valid & res_mispredict & in_flight;
    assign mis_acc    = mis_hit & ~flush;
    assign push       = pred_valid & pred_ready & ~mis_acc & ~flush;
    assign commit_acc = commit_valid & (count_q != '0);
    // A mispredict resolving the head in the commit cycle supplies the corrected outcome.
    assign commit_out = (mis_hit && res_id == head_q) ? res_taken : out_mem[head_q];

    always_comb begin
        ret_d      = ret_q;
        spec_d     = spec_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_base = count_q;
        count_d    = count_q;

        if (commit_acc) begin
            ret_d  = (ret_q << 1) | {{(HISTORY_SIZE-1){1'b0}}, commit_out};
            head_d = head_q + PTR_ONE;
        end

        if (flush) begin
            spec_d  = ret_d;
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (mis_acc) begin
                spec_d     = (hist_mem[res_id] << 1) | {{(HISTORY_SIZE-1){1'b0}}, res_taken};
                tail_d     = res_id + PTR_ONE;
                count_base = {1'b0, res_off} + CNT_ONE;
            end else if (push) begin
                spec_d     = (spec_q << 1) | {{(HISTORY_SIZE-1){1'b0}}, pred_taken};
                tail_d     = tail_q + PTR_ONE;
                count_base = count_q + CNT_ONE;
            end
            count_d = commit_acc ? (count_base - CNT_ONE) : count_base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            spec_q  <= '0;
            ret_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            spec_q  <= spec_d;
            ret_q   <= ret_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Checkpoint contents need no reset: only entries inside [head, tail) are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            hist_mem[tail_q] <= spec_q;
            out_mem[tail_q]  <= pred_taken;
        end else if (mis_acc) begin
            out_mem[res_id]  <= res_taken;
        end
    end

    assign pred_id         = tail_q;
    assign spec_history    = spec_q;
    assign retired_history = ret_q;
    assign ckpt_count      = count_q;

endmodule

// File: doc/spec_ghr.md
SPEC_GHR -- requirements
Module: spec_ghr

Interface
REQ-001 SHALL have parameter HISTORY_SIZE, default 64, meaning global history length in bits (>=2).
REQ-002 SHALL have parameter CKPT_DEPTH, default 8, meaning max in-flight predicted branches (power of 2, >=2); IDW = $clog2(CKPT_DEPTH).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-high (1 = reset).
REQ-005 SHALL have port pred_valid  in  1  fetch issues a predicted conditional branch this cycle.
REQ-006 SHALL have port pred_taken  in  1  predicted direction (1 = TAKEN).
REQ-007 SHALL have port pred_ready  out  1  checkpoint slot available (count < CKPT_DEPTH).
REQ-008 SHALL have port pred_id  out  IDW  checkpoint id assigned to a pred_valid accepted this cycle (= tail pointer).
REQ-009 SHALL have port res_valid  in  1  execute resolves an in-flight branch.
REQ-010 SHALL have port res_id  in  IDW  checkpoint id of the resolving branch.
REQ-011 SHALL have port res_mispredict  in  1  resolved direction differs from prediction.
REQ-012 SHALL have port res_taken  in  1  actual direction.
REQ-013 SHALL have port commit_valid  in  1  oldest in-flight branch retires.
REQ-014 SHALL have port flush  in  1  pipeline flush (exception); discard all speculation.
REQ-015 SHALL have port spec_history  out  HISTORY_SIZE  speculative history for the predictor; LSB = youngest outcome.
REQ-016 SHALL have port retired_history  out  HISTORY_SIZE  architectural history of committed branches.
REQ-017 SHALL have port ckpt_count  out  IDW+1  number of in-flight checkpoints.

Function
REQ-018 SHALL hold a circular buffer of CKPT_DEPTH entries, each: pre-shift history (HISTORY_SIZE bits) + outcome bit; head/tail pointers wrap modulo CKPT_DEPTH.
REQ-019 Accepted predict (pred_valid & pred_ready, no mispredict/flush this cycle): entry[tail] <= {spec_history, pred_taken}; spec_history <= {spec_history[HISTORY_SIZE-2:0], pred_taken}; tail++, count++.
REQ-020 pred_valid while pred_ready=0 SHALL be ignored with no state change.
REQ-021 res_id is in flight iff ((res_id - head) mod CKPT_DEPTH) < count; res_valid with an id not in flight SHALL be ignored.
REQ-022 res_valid & ~res_mispredict SHALL cause no state change.
REQ-023 In-flight mispredict: spec_history <= {entry[res_id].hist[HISTORY_SIZE-2:0], res_taken}; entry[res_id].outcome <= res_taken; tail <= res_id+1; all younger entries discarded; count recomputed.
REQ-024 pred_valid in the same cycle as an accepted mispredict SHALL be dropped (not allocated).
REQ-025 commit_valid with count>0: retired_history <= {retired_history[HISTORY_SIZE-2:0], outcome}, head++, count--; outcome = res_taken if an accepted mispredict targets head the same cycle, else entry[head].outcome.
REQ-026 commit_valid with count=0 SHALL be ignored.
REQ-027 Commit and predict (or commit and mispredict) in one cycle SHALL both apply; count = old count + pushes - pops - discards.
REQ-028 flush SHALL take priority over predict and mispredict: spec_history <= retired_history value after any same-cycle commit; head = tail; count = 0.
REQ-029 pred_ready, pred_id, ckpt_count, spec_history, retired_history SHALL be driven from registers only (no combinational path from inputs).
REQ-030 Zero-latency semantics: a change is visible on outputs the cycle after the causing edge.

Reset
REQ-031 With rst_n=1 at a posedge: spec_history=0, retired_history=0, head=tail=0, ckpt_count=0, pred_ready=1, pred_id=0; entry contents don't-care.
REQ-032 Reset SHALL override all other inputs in the same cycle, including mid-operation with full buffer.

Verification (HISTORY_SIZE=8, CKPT_DEPTH=4)
REQ-033 Reset with buffer full -> next cycle spec=retired=8'h00, ckpt_count=0, pred_ready=1, pred_id=0.
REQ-034 Predict T,N,T on consecutive cycles -> pred_id 0,1,2; spec_history=8'b0000_0101; ckpt_count=3.
REQ-035 Four predicts then fifth pred_valid -> pred_ready=0 after fourth, fifth ignored, ckpt_count=4, spec unchanged.
REQ-036 After T,N,T: mispredict res_id=1, res_taken=1 -> spec_history=8'b0000_0011, ckpt_count=2, pred_id=2; same-cycle pred_valid dropped.
REQ-037 Then commit twice -> retired_history=8'b0000_0011, ckpt_count=0; commit with count=0 ignored.
REQ-038 Three in flight, retired=8'h01, flush with commit_valid same cycle -> retired=8'b0000_0011 (head outcome T), spec_history=retired, ckpt_count=0.
